// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: data-memory req/ack handshake, stall, MEM/WB register.
// Timeout aborts a hung access; mem_err records faults until reset.
module mem_stage_ctrl #(
    parameter int DATA_W      = 16,
    parameter int RA_W        = 4,
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_mem_MEM,
    input  logic              re_mem_MEM,
    input  logic [DATA_W-1:0] alu_result_MEM,
    input  logic [DATA_W-1:0] sdata_MEM,
    input  logic [RA_W-1:0]   dst_addr_MEM,
    input  logic              we_rf_MEM,
    input  logic              wb_sel_MEM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall,
    output logic [DATA_W-1:0] wb_data_WB,
    output logic [RA_W-1:0]   dst_addr_WB,
    output logic              we_rf_WB,
    output logic              mem_err
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam bit             TO_EN   = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              op;
    logic              acc;
    logic              start;
    logic              timeout;
    logic              done;
    logic [DATA_W-1:0] rdata_sel;

    assign op      = we_mem_MEM | re_mem_MEM;
    assign acc     = (state == ACCESS);
    assign start   = (state == IDLE) & op;
    assign timeout = acc & TO_EN & (cnt == TO_LAST) & ~mem_ack;
    assign done    = acc & (mem_ack | timeout);
    assign stall   = op & ~done;

    // Load data: memory data on ack, zero when the access timed out
    assign rdata_sel = (acc & mem_ack) ? mem_rdata : '0;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next state: enter ACCESS on a mem op, leave on ack or timeout
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (op)   state_nxt = ACCESS;
            ACCESS:  if (done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory request and latched address/data/direction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (start) begin
            mem_req   <= 1'b1;
            mem_we    <= we_mem_MEM;
            mem_addr  <= alu_result_MEM;
            mem_wdata <= sdata_MEM;
        end else if (done) begin
            mem_req   <= 1'b0;
        end
    end

    // Access-cycle counter, cleared whenever the FSM is idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   cnt <= '0;
        else if (acc) cnt <= cnt + 1'b1;
        else          cnt <= '0;
    end

    // Sticky error: conflicting we/re at entry, or a timed-out access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mem_err <= 1'b0;
        else if ((start & we_mem_MEM & re_mem_MEM) | timeout)
            mem_err <= 1'b1;
    end

    // MEM/WB register: advance when not stalled, insert a bubble otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_data_WB  <= '0;
            dst_addr_WB <= '0;
            we_rf_WB    <= 1'b0;
        end else if (!stall) begin
            wb_data_WB  <= (wb_sel_MEM & re_mem_MEM) ? rdata_sel
                                                     : alu_result_MEM;
            dst_addr_WB <= dst_addr_MEM;
            we_rf_WB    <= we_rf_MEM;
        end else begin
            we_rf_WB    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with a writeback scoreboard.
// Memory acks are driven inline per access with a chosen latency.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we_mem_MEM, re_mem_MEM;
    logic [15:0] alu_result_MEM, sdata_MEM;
    logic [3:0]  dst_addr_MEM;
    logic        we_rf_MEM, wb_sel_MEM;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack, stall;
    logic [15:0] wb_data_WB;
    logic [3:0]  dst_addr_WB;
    logic        we_rf_WB, mem_err;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  a;
        logic        w;
    } wb_t;

    wb_t sb_q[$];
    int  n_chk  = 0;
    int  n_fail = 0;

    mem_stage_ctrl #(
        .DATA_W(16), .RA_W(4), .TIMEOUT_CYC(4), .CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .we_mem_MEM(we_mem_MEM), .re_mem_MEM(re_mem_MEM),
        .alu_result_MEM(alu_result_MEM), .sdata_MEM(sdata_MEM),
        .dst_addr_MEM(dst_addr_MEM), .we_rf_MEM(we_rf_MEM),
        .wb_sel_MEM(wb_sel_MEM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall(stall), .wb_data_WB(wb_data_WB), .dst_addr_WB(dst_addr_WB),
        .we_rf_WB(we_rf_WB), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nop();
        we_mem_MEM = 0; re_mem_MEM = 0; we_rf_MEM = 0; wb_sel_MEM = 0;
        alu_result_MEM = 0; sdata_MEM = 0; dst_addr_MEM = 0; mem_ack = 0;
    endtask

    // Drive one instruction, answer its memory access, check the retire.
    task automatic run_op(input string tag, input logic we, input logic re,
                          input logic [15:0] alu, input logic [15:0] sd,
                          input logic [3:0] dst, input logic wrf,
                          input logic wsel, input int ack_at,
                          input logic [15:0] rd, input int exp_stall,
                          input int exp_req, input logic [15:0] exp_wb);
        int  n, k, c;
        bit  fin;
        wb_t e;
        we_mem_MEM = we; re_mem_MEM = re; alu_result_MEM = alu;
        sdata_MEM = sd; dst_addr_MEM = dst; we_rf_MEM = wrf;
        wb_sel_MEM = wsel; mem_ack = 0;
        sb_q.push_back('{d: exp_wb, a: dst, w: wrf});
        n = 0; k = 0; c = 0; fin = 0;
        while (!fin && c < 32) begin
            c++;
            if (mem_req) begin
                k++;
                chk({tag, "_bubble"}, {31'b0, we_rf_WB}, 32'd0);
                chk({tag, "_addr"}, {16'b0, mem_addr}, {16'b0, alu});
                chk({tag, "_wdata"}, {16'b0, mem_wdata}, {16'b0, sd});
                chk({tag, "_we"}, {31'b0, mem_we}, {31'b0, we});
                mem_ack   = (k == ack_at);
                mem_rdata = (k == ack_at) ? rd : 16'hDEAD;
            end else begin
                mem_ack = 0;
            end
            #1;
            if (!stall) fin = 1;
            else begin
                n++;
                @(posedge clk); #1;
            end
        end
        chk({tag, "_completed"}, {31'b0, fin}, 32'd1);
        chk({tag, "_stall_cyc"}, n, exp_stall);
        chk({tag, "_req_cyc"}, k, exp_req);
        @(posedge clk); #1;
        mem_ack = 0;
        chk({tag, "_req_low"}, {31'b0, mem_req}, 32'd0);
        e = sb_q.pop_front();
        chk({tag, "_wb_data"}, {16'b0, wb_data_WB}, {16'b0, e.d});
        chk({tag, "_wb_dst"}, {28'b0, dst_addr_WB}, {28'b0, e.a});
        chk({tag, "_wb_we"}, {31'b0, we_rf_WB}, {31'b0, e.w});
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req"}, {31'b0, mem_req}, 32'd0);
        chk({tag, "_we"}, {31'b0, mem_we}, 32'd0);
        chk({tag, "_addr"}, {16'b0, mem_addr}, 32'd0);
        chk({tag, "_wdata"}, {16'b0, mem_wdata}, 32'd0);
        chk({tag, "_wbd"}, {16'b0, wb_data_WB}, 32'd0);
        chk({tag, "_dst"}, {28'b0, dst_addr_WB}, 32'd0);
        chk({tag, "_wbwe"}, {31'b0, we_rf_WB}, 32'd0);
        chk({tag, "_err"}, {31'b0, mem_err}, 32'd0);
    endtask

    initial begin
        rst_n = 0;
        mem_rdata = 0;
        nop();
        #12;
        chk_zero("reset");
        chk("reset_stall", {31'b0, stall}, 32'd0);
        rst_n = 1;
        @(posedge clk); #1;

        // ALU op: no stall, retires next edge
        run_op("alu", 0, 0, 16'h1234, 16'h0, 4'd3, 1, 0,
               0, 16'h0, 0, 0, 16'h1234);

        // Load, ack in 4th ACCESS cycle (also ack beats timeout)
        run_op("load", 0, 1, 16'h0040, 16'h0, 4'd5, 1, 1,
               4, 16'hBEEF, 4, 4, 16'hBEEF);

        // Store, ack in 1st ACCESS cycle
        run_op("store", 1, 0, 16'h0010, 16'h00A5, 4'd0, 0, 0,
               1, 16'h0, 1, 1, 16'h0010);

        // Back-to-back loads with immediate ack
        run_op("ld_b2b_a", 0, 1, 16'h0100, 16'h0, 4'd7, 1, 1,
               1, 16'h1111, 1, 1, 16'h1111);
        run_op("ld_b2b_b", 0, 1, 16'h0102, 16'h0, 4'd8, 1, 1,
               1, 16'h2222, 1, 1, 16'h2222);
        chk("err_clean", {31'b0, mem_err}, 32'd0);

        // Timeout load: never acked, returns 0, sets mem_err
        run_op("tmo", 0, 1, 16'h0200, 16'h0, 4'd9, 1, 1,
               0, 16'h0, 4, 4, 16'h0000);
        chk("tmo_err", {31'b0, mem_err}, 32'd1);
        run_op("alu2", 0, 0, 16'h0BAD, 16'h0, 4'd2, 1, 0,
               0, 16'h0, 0, 0, 16'h0BAD);
        chk("tmo_err_sticky", {31'b0, mem_err}, 32'd1);

        // Reset in the middle of an access
        we_mem_MEM = 0; re_mem_MEM = 1; alu_result_MEM = 16'h0300;
        dst_addr_MEM = 4'd4; we_rf_MEM = 1; wb_sel_MEM = 1; mem_ack = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_pre_req", {31'b0, mem_req}, 32'd1);
        rst_n = 0;
        #1;
        chk_zero("rst_mid");
        chk("rst_mid_stall", {31'b0, stall}, 32'd1);
        re_mem_MEM = 0;
        #1;
        chk("rst_mid_stall_nop", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        run_op("rst_reload", 0, 1, 16'h0300, 16'h0, 4'd4, 1, 1,
               2, 16'hCAFE, 2, 2, 16'hCAFE);
        chk("rst_err_clr", {31'b0, mem_err}, 32'd0);

        // we and re together: performed as a write, flags mem_err
        run_op("we_re", 1, 1, 16'h0400, 16'h5A5A, 4'd1, 0, 0,
               1, 16'h0, 1, 1, 16'h0400);
        chk("we_re_err", {31'b0, mem_err}, 32'd1);

        nop();
        @(posedge clk); #1;
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
